// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
//
// Receives a byte stream over a valid/ready handshake. The first two bytes form a
// little-endian length header (in words). The following bytes are assembled into
// little-endian 32-bit words, each written once at consecutive word addresses from 0.
// The core is held in reset (cpu_rst low) until the whole image has been written.
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-low reset
//   start     begin a load; only honoured when idle, done or in error
//   rx_data   incoming byte
//   rx_valid  rx_data valid this cycle
//   rx_ready  loader accepts a byte this cycle
//   we        one-cycle instruction-memory write strobe
//   wa        write byte address (word index << 2)
//   wd        write data word
//   cpu_rst   active-low core reset, released once the image is complete
//   busy      load in progress
//   done      image written successfully
//   err       bad length header (zero or larger than DEPTH)
module imem_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IdxW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWr,
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;

  logic              accept;
  logic [LEN_W-1:0]  len_hdr;
  logic [31:0]       word_next;
  logic              last_word;

  assign rx_ready = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData);
  assign accept   = rx_valid && rx_ready;

  // Full header as it stands once the high byte arrives.
  assign len_hdr   = LEN_W'({rx_data, len_q[7:0]});
  // Bytes shift in from the top so byte k ends up at bits [8k+7:8k] after four.
  assign word_next = {rx_data, word_q[31:8]};
  assign last_word = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLen0;
      end
      StLen0: begin
        if (accept) begin
          len_d   = LEN_W'(rx_data);
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d = len_hdr;
          if ((len_hdr == '0) || (32'(len_hdr) > DEPTH)) begin
            state_d = StErr;
          end else begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = word_next;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            // Latch the write beat now so wa/wd are stable for the whole WR cycle
            // and hold afterwards.
            wa_d    = 32'({idx_q, 2'b00});
            wd_d    = word_next;
            state_d = StWr;
          end
        end
      end
      StWr: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StData;
        end
      end
      StDone, StErr: begin
        if (start) state_d = StLen0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign we      = (state_q == StWr);
  assign wa      = wa_q;
  assign wd      = wd_q;
  assign done    = (state_q == StDone);
  assign cpu_rst = (state_q == StDone);
  assign err     = (state_q == StErr);
  assign busy    = (state_q == StLen0) || (state_q == StLen1) ||
                   (state_q == StData) || (state_q == StWr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/data streaming, error headers, full-depth
// image, stalled source, mid-load reset and restart from DONE.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Scoreboard of expected words for the current load.
  logic [31:0] exp_words[$];
  int          wr_cnt  = 0;
  int          bad_rdy = 0;
  logic [31:0] last_wa = '0;

  imem_loader #(
    .DEPTH(1024),
    .LEN_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe is compared against the scoreboard.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (rx_ready !== 1'b0) bad_rdy++;
      if (wr_cnt < exp_words.size()) begin
        check("wr_wa", wa, 32'(wr_cnt) << 2);
        check("wr_wd", wd, exp_words[wr_cnt]);
      end else begin
        check("extra_write", 32'(wr_cnt), 32'(exp_words.size() - 1));
      end
      last_wa = wa;
      wr_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50 && rx_ready !== 1'b1; i++) @(negedge clk);
    if (rx_ready !== 1'b1) check("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'hxx;
  endtask

  task automatic send_header(input logic [15:0] len);
    send_byte(len[7:0], 0);
    send_byte(len[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic new_load();
    exp_words.delete();
    wr_cnt  = 0;
    bad_rdy = 0;
  endtask

  task automatic load_test1(input int gap_max);
    new_load();
    exp_words.push_back(32'hFFC4A303);
    exp_words.push_back(32'h00832383);
    pulse_start();
    send_header(16'h0002);
    send_word(32'hFFC4A303, gap_max);
    send_word(32'h00832383, gap_max);
    // Now in the final WR cycle; done follows one cycle later.
    check("t1_we_last", {31'b0, we}, 32'd1);
    check("t1_done_early", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("t1_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {rx_ready, we, cpu_rst, busy, done, err}, 32'd0);
    check("rst_wa", wa, 32'd0);
    check("rst_wd", wd, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    // Idle must not accept bytes.
    rx_valid = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, rx_ready}, 32'd0);
    rx_valid = 1'b0;

    // 1: basic two-word image
    load_test1(0);

    // 2: zero-length header
    new_load();
    pulse_start();
    check("t2_cpu_rst_restart", {31'b0, cpu_rst}, 32'd0);
    check("t2_busy", {31'b0, busy}, 32'd1);
    send_header(16'h0000);
    check("t2_err", {31'b0, err}, 32'd1);
    check("t2_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("t2_ready", {31'b0, rx_ready}, 32'd0);
    pulse_start();
    check("t2_err_clr", {31'b0, err}, 32'd0);
    check("t2_len0_ready", {31'b0, rx_ready}, 32'd1);

    // 3: oversize header, then maximum-size image
    send_header(16'h0401);
    check("t3_err_1025", {31'b0, err}, 32'd1);
    new_load();
    for (int i = 0; i < 1024; i++) exp_words.push_back(32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000);
    pulse_start();
    send_header(16'h0400);
    check("t3_no_err_1024", {31'b0, err}, 32'd0);
    for (int i = 0; i < 1024; i++) send_word(exp_words[i], 0);
    @(negedge clk);
    check("t3_done", {31'b0, done}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd1024);
    check("t3_last_wa", last_wa, 32'h0000_0FFC);

    // 4: test 1 with random source gaps
    load_test1(5);
    check("t4_ready_in_wr", 32'(bad_rdy), 32'd0);

    // 5: reset in the middle of the second word
    new_load();
    exp_words.push_back(32'hFFC4A303);
    exp_words.push_back(32'h00832383);
    pulse_start();
    send_header(16'h0002);
    send_word(32'hFFC4A303, 0);
    send_byte(8'h83, 0);
    send_byte(8'h23, 0);
    rst = 1'b0;
    #1;
    check("t5_outs", {rx_ready, we, cpu_rst, busy, done, err}, 32'd0);
    check("t5_wa", wa, 32'd0);
    check("t5_wd", wd, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_idle_busy", {31'b0, busy}, 32'd0);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd1);
    load_test1(0);

    // 6: start during DATA ignored; restart from DONE with a one-word image
    new_load();
    exp_words.push_back(32'h00000013);
    pulse_start();
    check("t6_cpu_rst_low", {31'b0, cpu_rst}, 32'd0);
    send_header(16'h0001);
    send_byte(8'h13, 0);
    pulse_start();
    check("t6_busy_after_start", {31'b0, busy}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t6_we", {31'b0, we}, 32'd1);
    @(negedge clk);
    check("t6_done", {31'b0, done}, 32'd1);
    repeat (2) @(negedge clk);
    check("t6_wr_cnt", 32'(wr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
